// File: rtl/regfile_mp.sv
// Multi-port register file: NW write ports, NR read ports, debug tap, sequenced clear engine.
// Optional same-cycle write-to-read bypass when RF_BYPASS_EN is defined.
module regfile_mp #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int NW       = 2,
  parameter int NR       = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] waddr,
  input  logic [NW*DW-1:0] wdata,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR*DW-1:0] rdata,
  input  logic [AW-1:0]    dbg_addr,
  output logic [DW-1:0]    dbg_data,
  input  logic             clr_req,
  output logic             busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state;
  logic [AW-1:0]   clr_ptr;
  logic [DW-1:0]   mem [DEPTH];
  logic [NW-1:0]   wq;

  // A write qualifies only when idle and not aimed at a hardwired zero entry.
  always_comb begin
    wq = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      wq[i] = we[i] && !busy &&
              !((ZERO_REG != 0) && (waddr[i*AW +: AW] == '0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clr_ptr <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_ptr <= '0;
          end
        end
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == AW'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Ascending port order lets the highest-index port win address conflicts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else begin
      for (int unsigned i = 0; i < NW; i++) begin
        if (wq[i]) mem[waddr[i*AW +: AW]] <= wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned j = 0; j < NR; j++) begin
      rdata[j*DW +: DW] = mem[raddr[j*AW +: AW]];
`ifdef RF_BYPASS_EN
      for (int unsigned i = 0; i < NW; i++) begin
        if (wq[i] && (waddr[i*AW +: AW] == raddr[j*AW +: AW]))
          rdata[j*DW +: DW] = wdata[i*DW +: DW];
      end
`endif
      if (rst || ((ZERO_REG != 0) && (raddr[j*AW +: AW] == '0)))
        rdata[j*DW +: DW] = '0;
    end
  end

  assign dbg_data = (rst || ((ZERO_REG != 0) && (dbg_addr == '0))) ? '0 : mem[dbg_addr];

endmodule
